// File: rtl/uart_transmit_if.sv
// Byte-side handshake and serial line of the UART transmitter.
// The master drives the byte request; the slave is the transmitter itself.
interface uart_transmit_if;
  logic       parity_mode;
  logic [7:0] data_in;
  logic       tx_start;
  logic       ready;
  logic       serial_out;
  logic       tx_done;

  modport master (
    output parity_mode, data_in, tx_start,
    input  ready, serial_out, tx_done
  );

  modport slave (
    input  parity_mode, data_in, tx_start,
    output ready, serial_out, tx_done
  );
endinterface

// File: rtl/uart_transmit.sv
// UART transmitter: start bit, 8 data bits LSB first, odd/even parity, STOP_BITS stop bits.
// Define UART_TX_HOLD_EN to add a one-entry holding register for zero-gap back-to-back frames.
module uart_transmit #(
  parameter int CLKS_PER_BIT = 500,
  parameter int STOP_BITS    = 2
) (
  input  logic           ref_clk,
  input  logic           reset,
  uart_transmit_if.slave bus
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic              stop_idx;
  logic [7:0]        shift_reg;
  logic              parity_bit;
  logic              serial_q;
  logic              ready_q;
  logic              done_q;

  logic              bit_end;
  logic              frame_end;
  logic              accept;
  logic              load_frame;
  logic [7:0]        load_data;
  logic              load_mode;

`ifdef UART_TX_HOLD_EN
  logic              hold_valid;
  logic [7:0]        hold_data;
  logic              hold_mode;
`endif

  // Odd mode (even=0) makes the total count of ones across data+parity odd.
  function automatic logic parity_of(input logic [7:0] d, input logic even);
    return (^d) ^ ~even;
  endfunction

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
  assign accept    = bus.tx_start && ready_q;

  // Decide whether a new frame starts at this edge and where its byte comes from.
  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    load_frame = 1'b0;
    load_data  = bus.data_in;
    load_mode  = bus.parity_mode;
    if (state == IDLE) begin
      load_frame = accept;
    end
`ifdef UART_TX_HOLD_EN
    else if (frame_end) begin
      if (hold_valid) begin
        load_frame = 1'b1;
        load_data  = hold_data;
        load_mode  = hold_mode;
      end else begin
        load_frame = accept;
      end
    end
`endif
  end

  // NOTE: all state uses non-blocking assignments; later assignments in the block take priority.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      serial_q   <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
`ifdef UART_TX_HOLD_EN
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_mode  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end

      case (state)
        START: if (bit_end) begin
          state    <= DATA;
          bit_idx  <= '0;
          serial_q <= shift_reg[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state    <= PARITY;
            serial_q <= parity_bit;
          end else begin
            bit_idx   <= bit_idx + 3'd1;
            shift_reg <= {1'b0, shift_reg[7:1]};
            serial_q  <= shift_reg[1];
          end
        end
        PARITY: if (bit_end) begin
          state    <= STOP;
          stop_idx <= 1'b0;
          serial_q <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (stop_idx == STOP_LAST) begin
            state    <= IDLE;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            serial_q <= 1'b1;
          end else begin
            stop_idx <= stop_idx + 1'b1;
          end
        end
        default: ;
      endcase

      if (load_frame) begin
        state      <= START;
        baud_cnt   <= '0;
        bit_idx    <= '0;
        shift_reg  <= load_data;
        parity_bit <= parity_of(load_data, load_mode);
        serial_q   <= 1'b0;
`ifndef UART_TX_HOLD_EN
        ready_q    <= 1'b0;
`endif
      end

`ifdef UART_TX_HOLD_EN
      // A request while busy parks in the holding register; it drains at frame end.
      if (load_frame && frame_end && hold_valid) begin
        hold_valid <= 1'b0;
        ready_q    <= 1'b1;
      end else if (accept && !load_frame) begin
        hold_valid <= 1'b1;
        hold_data  <= bus.data_in;
        hold_mode  <= bus.parity_mode;
        ready_q    <= 1'b0;
      end
`endif
    end
  end

  assign bus.serial_out = serial_q;
  assign bus.ready      = ready_q;
  assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Self-checking bench for uart_transmit: a per-cycle frame-level line model plus
// directed literal frames, mid-frame reset, back-to-back and randomized traffic.
module tb_uart_transmit;

  localparam int CPB        = 4;
  localparam int SB         = 2;
  localparam int FRAME_BITS = 10 + SB;
  localparam int FRAME_CYC  = FRAME_BITS * CPB;
`ifdef UART_TX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic ref_clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   checking = 1'b0;

  uart_transmit_if bus();

  uart_transmit #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .ref_clk (ref_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line image of one frame, index 0 is the first bit on the wire.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] d, input logic even);
    logic [FRAME_BITS-1:0] f;
    int ones;
    ones = $countones(d);
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9] = even ? (ones % 2 == 1) : (ones % 2 == 0);
    return f;
  endfunction

  // ---------------- reference model: frames as timed line images ----------------
  int                    edge_n = 0;
  int                    fstart = 0;
  bit                    active = 1'b0;
  bit                    pend   = 1'b0;
  logic [FRAME_BITS-1:0] cur, pend_frame;
  logic                  exp_serial = 1'b1;
  logic                  exp_ready  = 1'b1;
  logic                  exp_done   = 1'b0;
  int                    model_dones = 0;
  int                    dut_dones   = 0;

  always @(posedge ref_clk) begin : model
    bit acc;
    bit ending;
    edge_n++;
    acc = bus.tx_start && exp_ready && !reset;
    if (reset) begin
      active     = 1'b0;
      pend       = 1'b0;
      exp_serial = 1'b1;
      exp_ready  = 1'b1;
      exp_done   = 1'b0;
    end else begin
      ending   = active && (edge_n - fstart == FRAME_CYC);
      exp_done = ending;
      if (ending) begin
        active = 1'b0;
        if (checking) model_dones++;
      end
      if (HOLD && pend && !active) begin
        active = 1'b1; fstart = edge_n; cur = pend_frame; pend = 1'b0;
      end
      if (acc) begin
        if (!active) begin
          active = 1'b1; fstart = edge_n; cur = make_frame(bus.data_in, bus.parity_mode);
        end else begin
          pend = 1'b1; pend_frame = make_frame(bus.data_in, bus.parity_mode);
        end
      end
      exp_serial = active ? cur[(edge_n - fstart) / CPB] : 1'b1;
      exp_ready  = HOLD ? !pend : !active;
    end
  end

  always @(negedge ref_clk) begin
    if (checking) begin
      check("serial_out", bus.serial_out, exp_serial);
      check("ready", bus.ready, exp_ready);
      check("tx_done", bus.tx_done, exp_done);
      if (bus.tx_done === 1'b1) dut_dones++;
    end
  end

  // Pulse tx_start for one edge, then capture the line at bit centres and tx_done latency.
  task automatic send_frame(input logic [7:0] d, input logic m,
                            output logic [FRAME_BITS-1:0] line, output int lat);
    bus.data_in     = d;
    bus.parity_mode = m;
    bus.tx_start    = 1'b1;
    @(negedge ref_clk);
    bus.tx_start    = 1'b0;
    bus.data_in     = 8'($urandom);
    bus.parity_mode = 1'($urandom);
    line = '0;
    lat  = -1;
    for (int j = 0; j <= 3 * FRAME_CYC; j++) begin
      if (j < FRAME_CYC && j % CPB == CPB / 2) line[j / CPB] = bus.serial_out;
      if (bus.tx_done === 1'b1) begin
        lat = j;
        break;
      end
      @(negedge ref_clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME_BITS-1:0] line;
    logic [7:0]            d;
    logic                  m;
    int                    lat;
    int                    d0;
    int                    cnt;

    reset           = 1'b1;
    bus.tx_start    = 1'b0;
    bus.data_in     = 8'h00;
    bus.parity_mode = 1'b0;
    repeat (2) @(negedge ref_clk);
    checking = 1'b1;
    check("reset_serial", bus.serial_out, 1'b1);
    check("reset_ready", bus.ready, 1'b1);
    check("reset_done", bus.tx_done, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge ref_clk);

    // Known frames
    send_frame(8'hCD, 1'b0, line, lat);
    check("cd_odd_line", line, 12'hD9A);
    check("cd_odd_latency", lat, 48);
    @(negedge ref_clk);
    send_frame(8'hCD, 1'b1, line, lat);
    check("cd_even_line", line, 12'hF9A);
    check("cd_even_latency", lat, 48);
    @(negedge ref_clk);
    send_frame(8'h47, 1'b0, line, lat);
    check("47_odd_line", line, 12'hE8E);
    repeat (4) @(negedge ref_clk);

    // Reset 17 cycles into a frame aborts it without tx_done
    bus.data_in = 8'hB6; bus.parity_mode = 1'b1; bus.tx_start = 1'b1;
    @(negedge ref_clk);
    bus.tx_start = 1'b0;
    repeat (17) @(negedge ref_clk);
    d0    = dut_dones;
    reset = 1'b1;
    @(negedge ref_clk);
    reset = 1'b0;
    check("abort_serial", bus.serial_out, 1'b1);
    check("abort_ready", bus.ready, 1'b1);
    check("abort_done", bus.tx_done, 1'b0);
    repeat (60) @(negedge ref_clk);
    check("abort_no_done", dut_dones - d0, 0);
    d = 8'($urandom); m = 1'($urandom);
    send_frame(d, m, line, lat);
    check("after_abort_line", line, make_frame(d, m));
    check("after_abort_latency", lat, 48);
    repeat (3) @(negedge ref_clk);

`ifndef UART_TX_HOLD_EN
    // tx_start held high: frames separated by exactly one idle cycle
    bus.data_in = 8'h55; bus.parity_mode = 1'b0; bus.tx_start = 1'b1;
    cnt = 0;
    for (int j = 0; j < 147; j++) begin
      @(negedge ref_clk);
      if (j == 48) check("gap_idle_high", bus.serial_out, 1'b1);
      if (j == 49) check("gap_next_start", bus.serial_out, 1'b0);
      if (bus.tx_done === 1'b1) cnt++;
    end
    bus.tx_start = 1'b0;
    check("held_start_frames", cnt, 3);
    repeat (60) @(negedge ref_clk);
`else
    // Holding register: second byte queued mid-frame starts with zero gap
    d0 = dut_dones;
    bus.data_in = 8'hCD; bus.parity_mode = 1'b0; bus.tx_start = 1'b1;
    @(negedge ref_clk);
    bus.tx_start = 1'b0;
    repeat (9) @(negedge ref_clk);
    check("hold_ready_busy", bus.ready, 1'b1);
    bus.data_in = 8'hA3; bus.parity_mode = 1'b1; bus.tx_start = 1'b1;
    @(negedge ref_clk);
    bus.tx_start = 1'b0;
    check("hold_ready_full", bus.ready, 1'b0);
    repeat (37) @(negedge ref_clk);
    check("hold_last_stop", bus.serial_out, 1'b1);
    @(negedge ref_clk);
    check("hold_done1", bus.tx_done, 1'b1);
    check("hold_zero_gap", bus.serial_out, 1'b0);
    repeat (48) @(negedge ref_clk);
    check("hold_done2", bus.tx_done, 1'b1);
    check("hold_done_count", dut_dones - d0, 2);
    repeat (10) @(negedge ref_clk);
`endif

    // Randomized traffic: random requests (many while busy), data, parity and rare resets
    for (int c = 0; c < 3000; c++) begin
      bus.tx_start    = ($urandom % 4 == 0);
      bus.data_in     = 8'($urandom);
      bus.parity_mode = 1'($urandom);
      reset           = ($urandom % 700 == 0);
      @(negedge ref_clk);
    end
    bus.tx_start = 1'b0;
    reset        = 1'b0;
    repeat (2 * FRAME_CYC + 10) @(negedge ref_clk);
    check("done_count", dut_dones, model_dones);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
